// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencing controller: state encoding,
// PC width, drain counter width and the default boot vector.
package fetch_pkg;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;

    localparam logic [1:0] BOOT      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] SYS_DRAIN = 2'd2;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'hBFC00000;

    typedef enum logic [1:0] {
        ST_BOOT      = BOOT,
        ST_RUN       = RUN,
        ST_SYS_DRAIN = SYS_DRAIN
    } state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Control bundle between hazard/branch logic, the fetch controller and the fetch stage.
// Perf counter outputs exist only when FETCH_CTRL_PERF_EN is defined.
interface fetch_ctrl_if import fetch_pkg::*; ();
    logic              hazard_stall;
    logic              imem_ready;
    logic              branch_req;
    logic [PC_W-1:0]   branch_target;
    logic              syscall_det;
    logic              if_stall;
    logic              if_req_alt;
    logic [PC_W-1:0]   if_alt_pc;
    logic              if_flush;
    logic              sys_active;
    logic [CNT_W-1:0]  sys_count;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0]       perf_stall_cyc;
    logic [31:0]       perf_redirects;
    logic [15:0]       perf_dropped;

    modport master (
        input  hazard_stall, imem_ready, branch_req, branch_target, syscall_det,
        output if_stall, if_req_alt, if_alt_pc, if_flush, sys_active, sys_count,
        output perf_stall_cyc, perf_redirects, perf_dropped
    );
    modport slave (
        output hazard_stall, imem_ready, branch_req, branch_target, syscall_det,
        input  if_stall, if_req_alt, if_alt_pc, if_flush, sys_active, sys_count,
        input  perf_stall_cyc, perf_redirects, perf_dropped
    );
`else
    modport master (
        input  hazard_stall, imem_ready, branch_req, branch_target, syscall_det,
        output if_stall, if_req_alt, if_alt_pc, if_flush, sys_active, sys_count
    );
    modport slave (
        output hazard_stall, imem_ready, branch_req, branch_target, syscall_det,
        input  if_stall, if_req_alt, if_alt_pc, if_flush, sys_active, sys_count
    );
`endif
endinterface

// File: rtl/fetch_redirect_buf.sv
// One-entry redirect buffer: accepts a branch target when idle and presents it
// for exactly one cycle; branches arriving during presentation are dropped.
module fetch_redirect_buf import fetch_pkg::*; #(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            branch_req_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic            pend_valid_o,
    output logic [PC_W-1:0] pend_pc_o,
    output logic            accept_o,
    output logic            drop_o
);
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;

    assign accept_o = branch_req_i & en_i & ~pend_valid_q;
    assign drop_o   = branch_req_i & ~accept_o;

    // Presentation never waits on the stall: the entry self-clears after one cycle.
    always_comb begin
        pend_valid_d = accept_o;
        pend_pc_d    = pend_pc_q;
        if (accept_o) begin
            pend_pc_d = branch_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= RESET_PC;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_pc_o    = pend_pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot vector load, branch redirects and syscall drain.
// Optional perf counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl import fetch_pkg::*; #(
    parameter int              SYS_DRAIN_CYC = 3,
    parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DEF
) (
    input  logic         CLK,
    input  logic         RESET,
    fetch_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYS_DRAIN_CYC - 1);

    state_e           state_q, state_d;
    logic             boot_q, boot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;

    logic             pend_valid;
    logic [PC_W-1:0]  pend_pc;
    logic             accept;
    logic             drop;
    logic             stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    fetch_redirect_buf #(.RESET_PC(RESET_PC)) u_redir (
        .clk_i           (CLK),
        .rst_i           (RESET),
        .en_i            (state_q != ST_BOOT),
        .branch_req_i    (bus.branch_req),
        .branch_target_i (bus.branch_target),
        .pend_valid_o    (pend_valid),
        .pend_pc_o       (pend_pc),
        .accept_o        (accept),
        .drop_o          (drop)
    );

    // BOOT spends its first post-reset cycle arming boot_q, then presents the vector.
    always_comb begin
        state_d = state_q;
        boot_d  = 1'b0;
        cnt_d   = cnt_q;
        act_d   = act_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_q) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.syscall_det && !bus.hazard_stall) begin
                    state_d = ST_SYS_DRAIN;
                    cnt_d   = '0;
                    act_d   = 1'b1;
                end
            end
            ST_SYS_DRAIN: begin
                if (bus.imem_ready) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        act_d   = 1'b0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_BOOT;
            boot_q  <= 1'b0;
            cnt_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    assign stall          = RESET | bus.hazard_stall | ~bus.imem_ready | (state_q != ST_RUN);
    assign bus.if_stall   = stall;
    assign bus.if_req_alt = boot_q | pend_valid;
    assign bus.if_alt_pc  = pend_pc;
    assign bus.if_flush   = pend_valid | ((state_q == ST_SYS_DRAIN) && (cnt_q == CNT_MAX));
    assign bus.sys_active = act_q;
    assign bus.sys_count  = cnt_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_redir_q;
    logic [15:0] perf_drop_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (stall && (state_q == ST_RUN)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (accept) begin
                perf_redir_q <= perf_redir_q + 32'd1;
            end
            if (drop) begin
                perf_drop_q <= perf_drop_q + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cyc = perf_stall_q;
    assign bus.perf_redirects = perf_redir_q;
    assign bus.perf_dropped   = perf_drop_q;
`else
    logic unused_perf;
    assign unused_perf = accept ^ drop;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl (SYS_DRAIN_CYC=3); perf checks are
// included when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_ctrl_if bus();

    fetch_ctrl #(.SYS_DRAIN_CYC(3), .RESET_PC(32'hBFC00000)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hazard_stall  = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.branch_req    = 1'b0;
        bus.branch_target = 32'h0;
        bus.syscall_det   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", bus.if_stall); end
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL rst_req_alt got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.if_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", bus.if_flush); end
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL rst_sys_active got=%b exp=0", bus.sys_active); end
        checks++; if (bus.sys_count !== 3'd0) begin errors++; $display("FAIL rst_sys_count got=%0d exp=0", bus.sys_count); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00000) begin errors++; $display("FAIL rst_alt_pc got=%h exp=bfc00000", bus.if_alt_pc); end
        rst = 1'b0;
        tick();
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL boot_req_alt got=%b exp=1", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00000) begin errors++; $display("FAIL boot_alt_pc got=%h exp=bfc00000", bus.if_alt_pc); end
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL boot_stall got=%b exp=1", bus.if_stall); end
        tick();
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL run_stall got=%b exp=0", bus.if_stall); end
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL run_req_alt got=%b exp=0", bus.if_req_alt); end
    endtask

    task automatic test_hazard();
        bus.hazard_stall = 1'b1;
        bus.syscall_det  = 1'b1;
        #1;
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL hazard_stall got=%b exp=1", bus.if_stall); end
        tick();
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL hazard_blocks_sys got=%b exp=0", bus.sys_active); end
        bus.hazard_stall = 1'b0;
        bus.syscall_det  = 1'b0;
        bus.imem_ready   = 1'b0;
        #1;
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL imem_stall got=%b exp=1", bus.if_stall); end
        tick();
        bus.imem_ready = 1'b1;
        #1;
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", bus.if_stall); end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (bus.perf_stall_cyc !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", bus.perf_stall_cyc); end
`endif
    endtask

    task automatic test_branch();
        bus.branch_req    = 1'b1;
        bus.branch_target = 32'hBFC00040;
        tick();
        bus.branch_req = 1'b0;
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL br_req_alt got=%b exp=1", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00040) begin errors++; $display("FAIL br_alt_pc got=%h exp=bfc00040", bus.if_alt_pc); end
        checks++; if (bus.if_flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b exp=1", bus.if_flush); end
        tick();
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL br_req_alt_clr got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.if_flush !== 1'b0) begin errors++; $display("FAIL br_flush_clr got=%b exp=0", bus.if_flush); end
    endtask

    task automatic test_back_to_back();
        bus.branch_req    = 1'b1;
        bus.branch_target = 32'hBFC00100;
        tick();
        checks++; if (bus.if_alt_pc !== 32'hBFC00100) begin errors++; $display("FAIL b2b_first_pc got=%h exp=bfc00100", bus.if_alt_pc); end
        bus.branch_target = 32'hBFC00200;
        tick();
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL b2b_drop_req got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00100) begin errors++; $display("FAIL b2b_drop_pc got=%h exp=bfc00100", bus.if_alt_pc); end
        bus.branch_target = 32'hBFC00300;
        tick();
        bus.branch_req = 1'b0;
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_req got=%b exp=1", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00300) begin errors++; $display("FAIL b2b_reaccept_pc got=%h exp=bfc00300", bus.if_alt_pc); end
        tick();
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (bus.perf_dropped !== 16'd1) begin errors++; $display("FAIL perf_dropped got=%0d exp=1", bus.perf_dropped); end
        checks++; if (bus.perf_redirects !== 32'd3) begin errors++; $display("FAIL perf_redirects got=%0d exp=3", bus.perf_redirects); end
`endif
    endtask

    task automatic test_syscall();
        logic [2:0] exp_cnt [3];
        logic       exp_fl  [3];
        exp_cnt = '{3'd0, 3'd1, 3'd2};
        exp_fl  = '{1'b0, 1'b0, 1'b1};
        bus.syscall_det = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.syscall_det = 1'b0;
            checks++; if (bus.sys_active !== 1'b1) begin errors++; $display("FAIL sys_active[%0d] got=%b exp=1", i, bus.sys_active); end
            checks++; if (bus.sys_count !== exp_cnt[i]) begin errors++; $display("FAIL sys_count[%0d] got=%0d exp=%0d", i, bus.sys_count, exp_cnt[i]); end
            checks++; if (bus.if_flush !== exp_fl[i]) begin errors++; $display("FAIL sys_flush[%0d] got=%b exp=%b", i, bus.if_flush, exp_fl[i]); end
            checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL sys_stall[%0d] got=%b exp=1", i, bus.if_stall); end
        end
        tick();
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL sys_done_active got=%b exp=0", bus.sys_active); end
        checks++; if (bus.sys_count !== 3'd0) begin errors++; $display("FAIL sys_done_count got=%0d exp=0", bus.sys_count); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL sys_done_stall got=%b exp=0", bus.if_stall); end
    endtask

    task automatic test_mem_wait();
        logic [2:0] exp_cnt [5];
        logic       imem    [5];
        exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
        imem    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.syscall_det = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.syscall_det = 1'b0;
            bus.imem_ready  = imem[i];
            checks++; if (bus.sys_count !== exp_cnt[i]) begin errors++; $display("FAIL wait_count[%0d] got=%0d exp=%0d", i, bus.sys_count, exp_cnt[i]); end
            checks++; if (bus.sys_active !== 1'b1) begin errors++; $display("FAIL wait_active[%0d] got=%b exp=1", i, bus.sys_active); end
        end
        checks++; if (bus.if_flush !== 1'b1) begin errors++; $display("FAIL wait_flush got=%b exp=1", bus.if_flush); end
        tick();
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL wait_done got=%b exp=0", bus.sys_active); end
    endtask

    task automatic test_sys_and_branch();
        bus.syscall_det   = 1'b1;
        bus.branch_req    = 1'b1;
        bus.branch_target = 32'hABCD0010;
        tick();
        bus.syscall_det = 1'b0;
        bus.branch_req  = 1'b0;
        checks++; if (bus.sys_active !== 1'b1) begin errors++; $display("FAIL sb_active got=%b exp=1", bus.sys_active); end
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL sb_req_alt got=%b exp=1", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hABCD0010) begin errors++; $display("FAIL sb_alt_pc got=%h exp=abcd0010", bus.if_alt_pc); end
        checks++; if (bus.if_flush !== 1'b1) begin errors++; $display("FAIL sb_flush got=%b exp=1", bus.if_flush); end
        tick();
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL sb_req_clr got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.sys_count !== 3'd1) begin errors++; $display("FAIL sb_count got=%0d exp=1", bus.sys_count); end
        tick();
        tick();
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL sb_done got=%b exp=0", bus.sys_active); end
    endtask

    task automatic test_reset_mid_drain();
        bus.syscall_det = 1'b1;
        tick();
        bus.syscall_det   = 1'b0;
        bus.branch_req    = 1'b1;
        bus.branch_target = 32'hDEAD0000;
        tick();
        bus.branch_req = 1'b0;
        checks++; if (bus.sys_count !== 3'd1) begin errors++; $display("FAIL mid_count got=%0d exp=1", bus.sys_count); end
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL mid_pend got=%b exp=1", bus.if_req_alt); end
        rst = 1'b1;
        tick();
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL mid_rst_req got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.if_flush !== 1'b0) begin errors++; $display("FAIL mid_rst_flush got=%b exp=0", bus.if_flush); end
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL mid_rst_active got=%b exp=0", bus.sys_active); end
        checks++; if (bus.sys_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", bus.sys_count); end
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL mid_rst_stall got=%b exp=1", bus.if_stall); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00000) begin errors++; $display("FAIL mid_rst_pc got=%h exp=bfc00000", bus.if_alt_pc); end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (bus.perf_redirects !== 32'd0) begin errors++; $display("FAIL mid_rst_perf got=%0d exp=0", bus.perf_redirects); end
`endif
        rst = 1'b0;
        tick();
        checks++; if (bus.if_req_alt !== 1'b1) begin errors++; $display("FAIL reboot_req got=%b exp=1", bus.if_req_alt); end
        checks++; if (bus.if_alt_pc !== 32'hBFC00000) begin errors++; $display("FAIL reboot_pc got=%h exp=bfc00000", bus.if_alt_pc); end
        checks++; if (bus.if_flush !== 1'b0) begin errors++; $display("FAIL reboot_flush got=%b exp=0", bus.if_flush); end
        tick();
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL reboot_run got=%b exp=0", bus.if_stall); end
        checks++; if (bus.if_req_alt !== 1'b0) begin errors++; $display("FAIL reboot_req_clr got=%b exp=0", bus.if_req_alt); end
        checks++; if (bus.sys_active !== 1'b0) begin errors++; $display("FAIL reboot_active got=%b exp=0", bus.sys_active); end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_back_to_back();
        test_syscall();
        test_mem_wait();
        test_sys_and_branch();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction fetch stage. Merges pipeline hazard stalls, instruction-memory wait, branch redirects and syscall drain.
- Produces the fetch stage's stall, alternate-PC request, alternate PC, bubble/flush and syscall status controls.
- Sits between ID/EXE hazard and branch logic and the fetch stage. Replaces the ad-hoc stall/redirect glue in the top level.

Parameters:
- SYS_DRAIN_CYC, 3: cycles the fetch stage is held after a syscall is detected (2..7).
- RESET_PC, 32'hBFC00000: PC presented on the first alternate-PC request after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- hazard_stall  in  1  load-use or structural stall from ID
- imem_ready  in  1  instruction memory returned valid data this cycle
- branch_req  in  1  taken branch or jump resolved this cycle
- branch_target  in  32  redirect target, valid with branch_req
- syscall_det  in  1  syscall decoded in ID this cycle
- if_stall  out  1  freeze the fetch stage
- if_req_alt  out  1  fetch stage must load if_alt_pc
- if_alt_pc  out  32  alternate PC
- if_flush  out  1  fetch stage must replace its output with a bubble (0)
- sys_active  out  1  syscall drain in progress
- sys_count  out  3  drain cycle index

Behaviour:
- Reset (RESET=1 at a clock edge), all values registered:
  - state=BOOT; pend_valid=0; if_alt_pc=RESET_PC.
  - if_req_alt=0, if_flush=0, sys_active=0, sys_count=0.
  - if_stall is forced to 1 while RESET is high.
  - Reset mid-drain or mid-redirect discards all pending state.
- States: BOOT, RUN, SYS_DRAIN.
- BOOT:
  - Lasts exactly one cycle after RESET deasserts.
  - Drives if_req_alt=1 with if_alt_pc=RESET_PC and if_stall=1, so fetch loads the boot vector.
  - Then goes to RUN.
- if_stall (combinational from registered state) = hazard_stall | !imem_ready | (state!=RUN).
- Redirect:
  - branch_req=1 while pend_valid=0 and not in BOOT: capture branch_target into pend_pc and set pend_valid.
  - Next cycle: if_req_alt=1, if_alt_pc=pend_pc, if_flush=1. Latency is 1 cycle.
  - pend_valid clears after exactly one presentation cycle, regardless of if_stall; the fetch stage loads the alternate PC even while stalled.
- Concurrent redirects:
  - branch_req while pend_valid=1 is ignored (wrong-path branch).
  - A branch_req in the same cycle pend_valid clears is accepted.
- RUN -> SYS_DRAIN on syscall_det=1 (and not hazard_stall): sys_count=0, sys_active=1.
- SYS_DRAIN:
  - sys_count increments by 1 each cycle, up to SYS_DRAIN_CYC-1.
  - if_flush=1 in the cycle sys_count==SYS_DRAIN_CYC-1.
  - Next cycle: state=RUN, sys_active=0, sys_count=0.
  - hazard_stall does not pause the count. imem_ready=0 does pause it: count and state hold.
- Simultaneous syscall_det and branch_req: the branch is captured and presented the next cycle and the drain starts in parallel; both proceed.
- branch_req during SYS_DRAIN is accepted normally; the redirect is presented while stalled.
- Widths:
  - sys_count saturates at SYS_DRAIN_CYC-1 and never wraps.
  - Addresses pass through unmodified; no alignment check.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc[31:0], perf_redirects[31:0] and perf_dropped[15:0].
  - perf_stall_cyc increments when if_stall=1 in RUN.
  - perf_redirects increments per accepted branch_req.
  - perf_dropped increments per ignored branch_req.
  - All counters wrap modulo 2^width and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (fetch_pkg): state encoding localparams BOOT=2'd0, RUN=2'd1, SYS_DRAIN=2'd2; RESET_PC constant; PC width 32.
- One sub-module is natural: fetch_redirect_buf, holding pend_valid/pend_pc, its accept/drop decision and the one-cycle presentation.
- The FSM and drain counter stay in the top module.

Test Plan:
- Reset: hold RESET 2 cycles, release with imem_ready=1 -> next cycle if_req_alt=1, if_alt_pc=BFC00000, if_stall=1; the cycle after, if_stall=0, state RUN.
- Branch: branch_req=1, branch_target=BFC00040 in RUN -> next cycle if_req_alt=1, if_alt_pc=BFC00040, if_flush=1; deasserted one cycle later.
- Back-to-back branches: branch_req on cycles N and N+1 with targets ...100 and ...200 -> only ...100 presented; perf_dropped=1 if FETCH_CTRL_PERF_EN is defined.
- Syscall: syscall_det=1 with SYS_DRAIN_CYC=3 -> sys_count 0,1,2 on consecutive cycles, if_flush=1 when sys_count=2, if_stall=1 for 3 cycles, then sys_active=0.
- Memory wait during drain: imem_ready=0 for 2 cycles mid-drain -> sys_count holds and the drain extends by 2 cycles.
- Reset mid-drain and with a pending redirect: RESET at sys_count=1 with pend_valid=1 -> all outputs return to reset values and the BOOT sequence repeats; no stale redirect is presented.
